// File: rtl/code_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_sweep_pkg
// Brief    : Shared state encoding and converter mode constants for the sweep
//            generator.
// Revision : 1.0
// ============================================================================
package code_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SWEEP_B2G = 3'd1,
        ST_GAP       = 3'd2,
        ST_SWEEP_G2B = 3'd3,
        ST_DONE      = 3'd4
    } sweep_state_t;

    // Must match the converter's model_sel encoding
    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sweep_hold_counter.sv
`default_nettype none
// ============================================================================
// Module   : sweep_hold_counter
// Brief    : Modulo-LIMIT up/down counter with synchronous clear and a
//            terminal-count flag asserted on the last enabled count.
// Revision : 1.0
// ============================================================================
module sweep_hold_counter #(
    parameter int LIMIT      = 3,
    parameter bit COUNT_DOWN = 1'b0,
    parameter int CNT_W      = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_first;
    logic [CNT_W-1:0] w_final;
    logic [CNT_W-1:0] w_step;

    generate
        if (COUNT_DOWN) begin : g_down
            assign w_first = c_last;
            assign w_final = '0;
            assign w_step  = r_count - c_one;
        end else begin : g_up
            assign w_first = '0;
            assign w_final = c_last;
            assign w_step  = r_count + c_one;
        end
    endgenerate

    assign tc = en && (r_count == w_final);

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            r_count <= w_first;
        end else if (en) begin
            r_count <= tc ? w_first : w_step;
        end
    end

endmodule
`default_nettype wire

// File: rtl/code_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : code_sweep_gen
// Brief    : Drives a Gray/binary converter through a full binary->Gray sweep,
//            an idle gap, then a full Gray->binary sweep, and pulses done.
// Revision : 1.0
// ============================================================================
module code_sweep_gen
    import code_sweep_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HOLD  = 3,
    parameter int GAP   = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] code_out,
    output logic             en,
    output logic             model_sel,
    output logic             busy,
    output logic             done
);

    generate
        if (HOLD < 1 || GAP < 1) begin : g_param_check
            $error("code_sweep_gen: HOLD and GAP must both be >= 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_code_max = '1;
    localparam logic [WIDTH-1:0] c_code_one = WIDTH'(1);

    sweep_state_t     r_state;
    sweep_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] w_code_nxt;
    logic             r_en;
    logic             r_sel;
    logic             r_busy;
    logic             r_done;
    logic             w_in_sweep;
    logic             w_in_gap;
    logic             w_hold_tc;
    logic             w_gap_tc;
    logic             w_nxt_sweep;
    logic             w_nxt_gap;

    assign w_in_sweep = (r_state == ST_SWEEP_B2G) || (r_state == ST_SWEEP_G2B);
    assign w_in_gap   = (r_state == ST_GAP);

    sweep_hold_counter #(
        .LIMIT      (HOLD),
        .COUNT_DOWN (1'b0)
    ) u_hold_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (!w_in_sweep || abort),
        .en   (w_in_sweep),
        .tc   (w_hold_tc)
    );

    sweep_hold_counter #(
        .LIMIT      (GAP),
        .COUNT_DOWN (1'b1)
    ) u_gap_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (!w_in_gap || abort),
        .en   (w_in_gap),
        .tc   (w_gap_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SWEEP_B2G;
                    w_code_nxt  = '0;
                end
            end
            ST_SWEEP_B2G, ST_SWEEP_G2B: begin
                if (w_hold_tc) begin
                    // The final code leaves the sweep instead of wrapping to 0
                    if (r_code == c_code_max) begin
                        w_state_nxt = (r_state == ST_SWEEP_B2G) ? ST_GAP : ST_DONE;
                        w_code_nxt  = '0;
                    end else begin
                        w_code_nxt  = r_code + c_code_one;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_tc) begin
                    w_state_nxt = ST_SWEEP_G2B;
                    w_code_nxt  = '0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = '0;
            end
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_code_nxt  = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    assign w_nxt_sweep = (w_state_nxt == ST_SWEEP_B2G) || (w_state_nxt == ST_SWEEP_G2B);
    assign w_nxt_gap   = (w_state_nxt == ST_GAP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_en    <= 1'b0;
            r_sel   <= MODE_B2G;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_en    <= w_nxt_sweep;
            r_sel   <= (w_nxt_gap || (w_state_nxt == ST_SWEEP_G2B)) ? MODE_G2B : MODE_B2G;
            r_busy  <= w_nxt_sweep || w_nxt_gap;
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign code_out  = r_code;
    assign en        = r_en;
    assign model_sel = r_sel;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_code_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_sweep_gen
// Brief    : Self-checking bench for code_sweep_gen against a cycle-indexed
//            reference model of the sweep sequence.
// Revision : 1.0
// ============================================================================
module tb_code_sweep_gen;

    localparam int W  = 8;
    localparam int H  = 3;
    localparam int G  = 20;
    localparam int SW = 4;
    localparam int SH = 1;
    localparam int SG = 1;
    localparam int TOTAL   = 2 * (1 << W) * H + G;
    localparam int S_TOTAL = 2 * (1 << SW) * SH + SG;

    typedef struct packed {
        logic [15:0] code;
        logic        en;
        logic        sel;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic s_start = 1'b0;
    logic s_abort = 1'b0;

    logic [W-1:0]  code_out;
    logic          en, model_sel, busy, done;
    logic [SW-1:0] s_code_out;
    logic          s_en, s_model_sel, s_busy, s_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    code_sweep_gen #(.WIDTH(W), .HOLD(H), .GAP(G)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .code_out(code_out), .en(en), .model_sel(model_sel), .busy(busy), .done(done)
    );

    code_sweep_gen #(.WIDTH(SW), .HOLD(SH), .GAP(SG)) u_small (
        .clk(clk), .rstn(rstn), .start(s_start), .abort(s_abort),
        .code_out(s_code_out), .en(s_en), .model_sel(s_model_sel), .busy(s_busy), .done(s_done)
    );

    // Expected outputs t cycles after the edge that accepted start
    function automatic exp_t model(input int t, input int w, input int h, input int g);
        exp_t e;
        int   n;
        e = '0;
        n = (1 << w) * h;
        if (t < 0) begin
            e = '0;
        end else if (t < n) begin
            e.code = 16'(t / h);
            e.en = 1'b1;
            e.busy = 1'b1;
        end else if (t < n + g) begin
            e.sel = 1'b1;
            e.busy = 1'b1;
        end else if (t < 2 * n + g) begin
            e.code = 16'((t - n - g) / h);
            e.en = 1'b1;
            e.sel = 1'b1;
            e.busy = 1'b1;
        end else if (t == 2 * n + g) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t obs_big();
        exp_t o;
        o.code = 16'(code_out);
        o.en = en;
        o.sel = model_sel;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    function automatic exp_t obs_small();
        exp_t o;
        o.code = 16'(s_code_out);
        o.en = s_en;
        o.sel = s_model_sel;
        o.busy = s_busy;
        o.done = s_done;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t o;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs_big();
            checks++;
            if (o !== exp_t'(0)) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, exp_t'(0));
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            abort = 1'($urandom_range(0, 1));
            tick();
            o = obs_big();
            checks++;
            if (o !== exp_t'(0)) begin
                failures++;
                $display("FAIL idle_no_start cyc=%0d got=%h exp=%h", i, o, exp_t'(0));
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_full_run();
        exp_t o, e;
        int busy_cnt = 0;
        int done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= TOTAL + 4; t++) begin
            o = obs_big();
            e = model(t, W, H, G);
            busy_cnt += int'(o.busy);
            done_cnt += int'(o.done);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL full_run t=%0d got=%h exp=%h", t, o, e);
            end
            tick();
        end
        checks++;
        if (busy_cnt != TOTAL) begin
            failures++;
            $display("FAIL full_run_busy_len got=%0d exp=%0d", busy_cnt, TOTAL);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL full_run_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_abort();
        exp_t o, e;
        int cut;
        for (int k = 0; k < 2; k++) begin
            cut = (k == 0) ? 400 : int'($urandom_range(1, TOTAL - 1));
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int t = 0; t <= cut + 5; t++) begin
                o = obs_big();
                e = (t <= cut) ? model(t, W, H, G) : exp_t'(0);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL abort cut=%0d t=%0d got=%h exp=%h", cut, t, o, e);
                end
                abort = (t == cut);
                tick();
            end
            abort = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int t = 0; t < 10; t++) begin
                o = obs_big();
                e = model(t, W, H, G);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL restart_after_abort t=%0d got=%h exp=%h", t, o, e);
                end
                tick();
            end
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    task automatic test_start_ignored();
        exp_t o, e;
        int done_cnt = 0;
        start = 1'b1;
        tick();
        for (int t = 0; t <= TOTAL + 5; t++) begin
            o = obs_big();
            e = model(t, W, H, G);
            done_cnt += int'(o.done);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL start_ignored t=%0d got=%h exp=%h", t, o, e);
            end
            if (t == 770 || t == TOTAL) start = 1'b1;
            else if (t < TOTAL) start = 1'($urandom_range(0, 3) == 0);
            else start = 1'b0;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL start_ignored_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= TOTAL + 21; t++) begin
            o = obs_big();
            e = (t <= TOTAL + 1) ? model(t, W, H, G) : model(t - (TOTAL + 2), W, H, G);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back t=%0d got=%h exp=%h", t, o, e);
            end
            start = (t == TOTAL + 1);
            tick();
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t o, e;
        int cut;
        cut = (1 << W) * H + G + int'($urandom_range(0, (1 << W) * H - 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= cut + 5; t++) begin
            o = obs_big();
            e = (t <= cut) ? model(t, W, H, G) : exp_t'(0);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid cut=%0d t=%0d got=%h exp=%h", cut, t, o, e);
            end
            rstn = (t != cut);
            tick();
        end
        rstn = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                abort = 1'b0;
                start = 1'b0;
            end
            tick();
            o = obs_big();
            checks++;
            if (o !== exp_t'(0)) begin
                failures++;
                $display("FAIL abort_start_idle cyc=%0d got=%h exp=%h", i, o, exp_t'(0));
            end
        end
    endtask

    task automatic test_small();
        exp_t o, e;
        int busy_cnt = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int t = 0; t <= S_TOTAL + 3; t++) begin
            o = obs_small();
            e = model(t, SW, SH, SG);
            busy_cnt += int'(o.busy);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL small_run t=%0d got=%h exp=%h", t, o, e);
            end
            tick();
        end
        checks++;
        if (busy_cnt != 33) begin
            failures++;
            $display("FAIL small_busy_len got=%0d exp=33", busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_full_run();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
